// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: receive-side byte buffer behind uart_rx.
// Captures each data_rdy strobe into a synchronous FIFO and presents the
// head byte on a first-word-fall-through valid/ready port.
// Optional feature macro: UART_RX_FIFO_OVF_CNT_EN enables the saturating
// dropped-byte counter on ovf_cnt. When it is undefined, ovf_cnt is tied to 0.
// All outputs come straight from flops. rd_dat is registered by computing the
// next head byte in the same cycle the pointers move.
module uart_rx_fifo #(
  parameter int DATA_LEN = 8,
  parameter int DEPTH    = 16,
  parameter int ADDR_W   = 4
) (
  input  logic                clk_sys,
  input  logic                rst,
  input  logic [DATA_LEN-1:0] rx_dat,
  input  logic                data_rdy,
  output logic [DATA_LEN-1:0] rd_dat,
  output logic                rd_valid,
  input  logic                rd_ready,
  output logic [ADDR_W:0]     count,
  output logic                full,
  output logic                empty,
  output logic                overflow,
  input  logic                ovf_clr,
  output logic [7:0]          ovf_cnt
);

  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);

  logic [DATA_LEN-1:0] mem_r [DEPTH];

  logic [ADDR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]     count_q, count_d;
  logic                full_q, full_d;
  logic                empty_q, empty_d;
  logic                rd_valid_q, rd_valid_d;
  logic [DATA_LEN-1:0] rd_dat_q, rd_dat_d;
  logic                overflow_q, overflow_d;

  logic push_s;
  logic pop_s;
  logic drop_s;

  // Handshake decode: a pop frees a slot, so a push at full is still taken.
  always_comb begin
    pop_s  = rd_ready & ~empty_q;
    push_s = data_rdy & (~full_q | pop_s);
    drop_s = data_rdy & full_q & ~pop_s;
  end

  // Next-state for pointers, occupancy, flags and the registered head byte.
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    rd_dat_d   = rd_dat_q;
    overflow_d = overflow_q;

    if (push_s) begin
      wr_ptr_d = wr_ptr_q + ADDR_W'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end

    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + ADDR_W'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end

    case ({push_s, pop_s})
      2'b10:   count_d = count_q + (ADDR_W+1)'(1);
      2'b01:   count_d = count_q - (ADDR_W+1)'(1);
      default: count_d = count_q;
    endcase

    full_d     = (count_d == DEPTH_C);
    empty_d    = (count_d == (ADDR_W+1)'(0));
    rd_valid_d = ~empty_d;

    // The incoming byte becomes the head when it lands in the slot the read
    // pointer will point at next (FIFO empty, or draining its last entry).
    if (empty_d) begin
      rd_dat_d = {DATA_LEN{1'b0}};
    end else if (push_s && (wr_ptr_q == rd_ptr_d)) begin
      rd_dat_d = rx_dat;
    end else begin
      rd_dat_d = mem_r[rd_ptr_d];
    end

    // A drop and a clear in the same cycle leave the flag set.
    if (drop_s) begin
      overflow_d = 1'b1;
    end else if (ovf_clr) begin
      overflow_d = 1'b0;
    end else begin
      overflow_d = overflow_q;
    end
  end

  // Control and status registers with synchronous reset.
  always_ff @(posedge clk_sys) begin
    if (rst) begin
      wr_ptr_q   <= {ADDR_W{1'b0}};
      rd_ptr_q   <= {ADDR_W{1'b0}};
      count_q    <= {(ADDR_W+1){1'b0}};
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
      rd_valid_q <= 1'b0;
      rd_dat_q   <= {DATA_LEN{1'b0}};
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      full_q     <= full_d;
      empty_q    <= empty_d;
      rd_valid_q <= rd_valid_d;
      rd_dat_q   <= rd_dat_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage array write port; contents are not reset.
  always_ff @(posedge clk_sys) begin
    if (push_s && !rst) begin
      mem_r[wr_ptr_q] <= rx_dat;
    end
  end

`ifdef UART_RX_FIFO_OVF_CNT_EN
  logic [7:0] ovf_cnt_q, ovf_cnt_d;

  // Saturating dropped-byte counter; a clear with a drop restarts at 1.
  always_comb begin
    ovf_cnt_d = ovf_cnt_q;
    if (ovf_clr) begin
      ovf_cnt_d = drop_s ? 8'd1 : 8'd0;
    end else if (drop_s && (ovf_cnt_q != 8'd255)) begin
      ovf_cnt_d = ovf_cnt_q + 8'd1;
    end else begin
      ovf_cnt_d = ovf_cnt_q;
    end
  end

  // Dropped-byte counter register.
  always_ff @(posedge clk_sys) begin
    if (rst) begin
      ovf_cnt_q <= 8'd0;
    end else begin
      ovf_cnt_q <= ovf_cnt_d;
    end
  end

  assign ovf_cnt = ovf_cnt_q;
`else
  assign ovf_cnt = 8'd0;
`endif

  assign rd_dat   = rd_dat_q;
  assign rd_valid = rd_valid_q;
  assign count    = count_q;
  assign full     = full_q;
  assign empty    = empty_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed testbench for uart_rx_fifo (DEPTH=16, DATA_LEN=8).
// Inputs change 1 time unit after a rising edge, and outputs are sampled at
// that same point.
module tb_uart_rx_fifo;

  logic       clk_sys;
  logic       rst;
  logic [7:0] rx_dat;
  logic       data_rdy;
  logic [7:0] rd_dat;
  logic       rd_valid;
  logic       rd_ready;
  logic [4:0] count;
  logic       full;
  logic       empty;
  logic       overflow;
  logic       ovf_clr;
  logic [7:0] ovf_cnt;

  int n_checks;
  int n_pass;

  uart_rx_fifo #(.DATA_LEN(8), .DEPTH(16), .ADDR_W(4)) dut (
    .clk_sys  (clk_sys),
    .rst      (rst),
    .rx_dat   (rx_dat),
    .data_rdy (data_rdy),
    .rd_dat   (rd_dat),
    .rd_valid (rd_valid),
    .rd_ready (rd_ready),
    .count    (count),
    .full     (full),
    .empty    (empty),
    .overflow (overflow),
    .ovf_clr  (ovf_clr),
    .ovf_cnt  (ovf_cnt)
  );

  // 100 MHz-style free-running clock.
  initial clk_sys = 1'b0;
  always #5 clk_sys = ~clk_sys;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs === exp_v) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic step();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic push(input logic [7:0] b);
    rx_dat   = b;
    data_rdy = 1'b1;
    step();
    data_rdy = 1'b0;
    rx_dat   = 8'h00;
  endtask

  task automatic fill16();
    for (int i = 0; i < 16; i++) push(8'(i));
  endtask

  task automatic drain_seq(input string tag, input int n, input int first);
    rd_ready = 1'b1;
    for (int i = 0; i < n; i++) begin
      check(tag, {24'd0, rd_dat}, 32'(8'(first + i)));
      step();
    end
    rd_ready = 1'b0;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, ".rd_dat"},   {24'd0, rd_dat}, 32'd0);
    check({tag, ".rd_valid"}, {31'd0, rd_valid}, 32'd0);
    check({tag, ".count"},    {27'd0, count}, 32'd0);
    check({tag, ".full"},     {31'd0, full}, 32'd0);
    check({tag, ".empty"},    {31'd0, empty}, 32'd1);
    check({tag, ".overflow"}, {31'd0, overflow}, 32'd0);
    check({tag, ".ovf_cnt"},  {24'd0, ovf_cnt}, 32'd0);
  endtask

  logic [7:0] exp_ovf2;
  logic [7:0] exp_ovf1;

  initial begin
    n_checks = 0;
    n_pass   = 0;
`ifdef UART_RX_FIFO_OVF_CNT_EN
    exp_ovf2 = 8'd2;
    exp_ovf1 = 8'd1;
`else
    exp_ovf2 = 8'd0;
    exp_ovf1 = 8'd0;
`endif
    rst = 1'b1; rx_dat = 8'h00; data_rdy = 1'b0; rd_ready = 1'b0; ovf_clr = 1'b0;
    step(); step();
    rst = 1'b0;
    check_reset_vals("reset");

    // rd_ready while empty is ignored.
    rd_ready = 1'b1; step(); rd_ready = 1'b0;
    check("empty_pop.count", {27'd0, count}, 32'd0);
    check("empty_pop.empty", {31'd0, empty}, 32'd1);

    // Single byte.
    push(8'hA5);
    check("single.rd_valid", {31'd0, rd_valid}, 32'd1);
    check("single.rd_dat",   {24'd0, rd_dat}, 32'hA5);
    check("single.count",    {27'd0, count}, 32'd1);
    check("single.empty",    {31'd0, empty}, 32'd0);
    rd_ready = 1'b1; step(); rd_ready = 1'b0;
    check("single_pop.rd_valid", {31'd0, rd_valid}, 32'd0);
    check("single_pop.rd_dat",   {24'd0, rd_dat}, 32'h00);
    check("single_pop.empty",    {31'd0, empty}, 32'd1);

    // Fill and drain three times to wrap the pointers.
    for (int r = 0; r < 3; r++) begin
      fill16();
      check("fill.full",  {31'd0, full}, 32'd1);
      check("fill.count", {27'd0, count}, 32'd16);
      drain_seq("fill.order", 16, 0);
      check("fill.empty", {31'd0, empty}, 32'd1);
      check("fill.rd_valid", {31'd0, rd_valid}, 32'd0);
    end

    // Overflow: two drops at full.
    fill16();
    push(8'hEE);
    push(8'hEF);
    check("ovf.overflow", {31'd0, overflow}, 32'd1);
    check("ovf.count",    {27'd0, count}, 32'd16);
    check("ovf.ovf_cnt",  {24'd0, ovf_cnt}, {24'd0, exp_ovf2});
    drain_seq("ovf.order", 16, 0);
    check("ovf.empty", {31'd0, empty}, 32'd1);
    check("ovf.sticky", {31'd0, overflow}, 32'd1);
    ovf_clr = 1'b1; step(); ovf_clr = 1'b0;
    check("ovf_clr.overflow", {31'd0, overflow}, 32'd0);
    check("ovf_clr.ovf_cnt",  {24'd0, ovf_cnt}, 32'd0);

    // Drop and clear in the same cycle: set wins, counter restarts at 1.
    fill16();
    rx_dat = 8'hDD; data_rdy = 1'b1; ovf_clr = 1'b1;
    step();
    data_rdy = 1'b0; ovf_clr = 1'b0;
    check("drop_clr.overflow", {31'd0, overflow}, 32'd1);
    check("drop_clr.ovf_cnt",  {24'd0, ovf_cnt}, {24'd0, exp_ovf1});
    ovf_clr = 1'b1; step(); ovf_clr = 1'b0;
    check("drop_clr2.overflow", {31'd0, overflow}, 32'd0);

    // Simultaneous push and pop at full: no drop.
    rx_dat = 8'h55; data_rdy = 1'b1; rd_ready = 1'b1;
    check("sim.head", {24'd0, rd_dat}, 32'h00);
    step();
    data_rdy = 1'b0; rd_ready = 1'b0;
    check("sim.count",    {27'd0, count}, 32'd16);
    check("sim.full",     {31'd0, full}, 32'd1);
    check("sim.overflow", {31'd0, overflow}, 32'd0);
    drain_seq("sim.order", 15, 1);
    check("sim.last", {24'd0, rd_dat}, 32'h55);
    rd_ready = 1'b1; step(); rd_ready = 1'b0;
    check("sim.empty", {31'd0, empty}, 32'd1);

    // Reset mid-stream with 5 bytes held and overflow set.
    fill16();
    push(8'hEE);
    drain_seq("mid.pre", 11, 0);
    check("mid.count_before", {27'd0, count}, 32'd5);
    check("mid.ovf_before",   {31'd0, overflow}, 32'd1);
    rst = 1'b1; rx_dat = 8'h77; data_rdy = 1'b1;
    step();
    rst = 1'b0; data_rdy = 1'b0;
    check_reset_vals("mid_reset");
    push(8'h3C);
    check("mid.first", {24'd0, rd_dat}, 32'h3C);
    check("mid.count", {27'd0, count}, 32'd1);
    rd_ready = 1'b1; step(); rd_ready = 1'b0;
    check("mid.empty", {31'd0, empty}, 32'd1);

    // Byte held while the consumer stalls for 1000 cycles.
    push(8'h55);
    for (int c = 0; c < 1000; c++) begin
      if ((c % 100) == 0) begin
        check("hold.rd_dat", {24'd0, rd_dat}, 32'h55);
        check("hold.count",  {27'd0, count}, 32'd1);
      end
      step();
    end
    check("hold.end_valid", {31'd0, rd_valid}, 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/uart_rx_fifo.md
# uart_rx_fifo

Receive-side byte buffer sitting directly downstream of `uart_rx`. Captures every byte presented on `uart_rx`'s `rx_dat`/`data_rdy` single-cycle strobe into a synchronous FIFO. Hands the bytes to the consumer through a first-word-fall-through valid/ready port. Decouples the serial line from a consumer (e.g. the `uart_tx` loopback path or a command parser) that cannot always accept a byte in the cycle it arrives.

## Interface
- `DATA_LEN`, default 8: byte width; must equal the `uart_rx` instance's `DATA_LEN`.
- `DEPTH`, default 16: number of entries; must be a power of two, minimum 2.
- `ADDR_W`, default 4: log2(`DEPTH`).

- `clk_sys`  in  1  system clock, same domain as `uart_rx`.
- `rst`  in  1  reset, synchronous, active-high.
- `rx_dat`  in  `DATA_LEN`  byte from `uart_rx`; valid only while `data_rdy`=1.
- `data_rdy`  in  1  write strobe from `uart_rx`, one cycle per received byte.
- `rd_dat`  out  `DATA_LEN`  head-of-FIFO byte; valid while `rd_valid`=1.
- `rd_valid`  out  1  FIFO non-empty.
- `rd_ready`  in  1  consumer accepts `rd_dat` this cycle.
- `count`  out  `ADDR_W+1`  current occupancy, 0..`DEPTH`.
- `full`  out  1  `count`==`DEPTH`.
- `empty`  out  1  `count`==0.
- `overflow`  out  1  sticky: a byte was dropped because the FIFO was full.
- `ovf_clr`  in  1  clears `overflow`.
- `ovf_cnt`  out  8  dropped-byte counter (see Configuration).

## Operation
- Storage: register array of `DEPTH`×`DATA_LEN`. Write pointer and read pointer are `ADDR_W` bits wide and wrap modulo `DEPTH`. Occupancy is held in an `ADDR_W+1` bit counter.
- Push: `data_rdy`=1 and (not full, or a pop in the same cycle). Writes `rx_dat` at the write pointer, then increments the pointer.
- Pop: `rd_valid`=1 and `rd_ready`=1. Increments the read pointer. `rd_ready` while empty is ignored.
- `count` update: push only → +1; pop only → −1; push and pop together → unchanged.
- Full with push and pop in the same cycle: both take effect, no drop, `full` stays 1.
- Empty with push: the byte is accepted. No pop is possible in the same cycle.
- Drop: `data_rdy`=1, full, and no pop. The byte is discarded, FIFO contents and pointers are unchanged, and `overflow` is set.
- `overflow`: set on a drop and held until `ovf_clr`=1. If a drop and `ovf_clr` occur in the same cycle, set wins.
- `rd_dat`: the entry at the read pointer when non-empty, forced to 0 when empty.
- Reset, including mid-stream: pointers and `count` go to 0, buffered bytes are discarded, `overflow`=0. A `data_rdy` in the reset cycle is ignored. Storage array is not reset.

## Timing
- Reset values: `rd_dat`=0, `rd_valid`=0, `count`=0, `full`=0, `empty`=1, `overflow`=0, `ovf_cnt`=0.
- Write-to-read latency is one cycle. A byte strobed at edge N is on `rd_dat` with `rd_valid`=1 after edge N.
- Pop takes effect at the edge where `rd_valid`&`rd_ready`=1. The next byte, or `rd_valid`=0, appears after that edge.
- `count`, `full`, `empty`, `overflow` and `ovf_cnt` are all registered and update at the same edge as the push or pop that changes them.
- No combinational path from `data_rdy` or `rd_ready` to any output.

## Configuration
- `UART_RX_FIFO_OVF_CNT_EN` defined: `ovf_cnt` counts dropped bytes. It saturates at 255, resets to 0, and is cleared by `ovf_clr`; a clear and a drop in the same cycle give 1.
- Not defined: `ovf_cnt` is tied to 0 and no counter logic is built. `overflow` behaves identically in both builds.

## Test plan
- Single byte: reset, then `data_rdy` pulse with 8'hA5, `rd_ready`=0 → next cycle `rd_valid`=1, `rd_dat`=8'hA5, `count`=1. Then `rd_ready`=1 for one cycle → `rd_valid`=0, `rd_dat`=0, `empty`=1.
- Fill and order: 16 strobes 8'h00..8'h0F with `rd_ready`=0 → `full`=1, `count`=16. Drain with `rd_ready`=1 → bytes emerge 00..0F in order, then `empty`=1. Repeat 3 times to exercise pointer wrap.
- Overflow: fill to 16, then strobe 8'hEE and 8'hEF → `overflow`=1, `count`=16, drained data is 00..0F with no EE/EF. `ovf_cnt`=2 with the macro, 0 without. Pulse `ovf_clr` → `overflow`=0 and `ovf_cnt`=0.
- Simultaneous at full: full, `rd_ready`=1 and strobe 8'h55 in the same cycle → no drop, `count`=16, and 8'h55 is the last byte out.
- Reset mid-stream: 5 bytes buffered and `overflow`=1, assert `rst` one cycle → all outputs at reset values. The next strobe 8'h3C is the first byte out.
- Loopback with `uart_rx` at 50 MHz / 115200 baud: serial frame 8'h55, consumer holding `rd_ready`=0 for 1000 cycles → byte held, `rd_dat`=8'h55, `count`=1 throughout.
